alu_cmd_issue: RTL and testbench

- Sequential front-end for the 4-bit gate-level ALU. Buffers incoming {A, B, op} commands in a small FIFO and drives them one at a time onto the ALU's A/B/S inputs from registers.
- Waits one settle cycle for the combinational ALU, captures its 8-bit out, and presents the result on a valid/ready handshake.
- Sits between the command source (testbench or future controller) and result consumer, with the existing ALU instantiated alongside it at top level.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_cmd_fifo.sv | 58 +++++
 rtl/alu_cmd_issue.sv | 125 ++++++++++++
 tb/tb_alu_cmd_issue.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command front-end.
// Contents: opcode constants, default widths and depth, command struct, FSM state type.
// Imported by the issue block, its FIFO and any controller that builds commands.
package alu_pkg;

  localparam int ALU_OPW   = 4;  // operand width seen by the ALU A/B inputs
  localparam int ALU_SW    = 3;  // opcode width seen by the ALU S input
  localparam int ALU_RW    = 8;  // ALU result width
  localparam int ALU_DEPTH = 4;  // default command queue depth

  localparam logic [ALU_SW-1:0] OP_ADD = 3'd0;
  localparam logic [ALU_SW-1:0] OP_SUB = 3'd1;
  localparam logic [ALU_SW-1:0] OP_MUL = 3'd2;
  localparam logic [ALU_SW-1:0] OP_AND = 3'd3;
  localparam logic [ALU_SW-1:0] OP_OR  = 3'd4;
  localparam logic [ALU_SW-1:0] OP_XOR = 3'd5;

  typedef struct packed {
    logic [ALU_OPW-1:0] a;
    logic [ALU_OPW-1:0] b;
    logic [ALU_SW-1:0]  op;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESULT = 2'd2
  } state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO, DEPTH entries of W bits, head visible without a pop.
// Ports: clk/rst_n/clr control; push + push_data write; pop advances head; count/full/empty status.
// Pushes when full and pops when empty are ignored; clr empties the queue and drops a same-cycle push.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter  int DEPTH = ALU_DEPTH,
  parameter  int W     = 2*ALU_OPW + ALU_SW,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full && !clr;
  assign pop_ok  = pop && !empty && !clr;
  assign head    = mem[rd_ptr];

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/alu_cmd_issue.sv
// Queues {A,B,op} commands, drives them one at a time into a combinational ALU, returns its result.
// Ports: in_* command handshake; alu_a/b/s out to the ALU, alu_out back; res_* result handshake; count.
// Accept to res_valid is two edges; results hold until res_ready; in_ready drops when the queue is full.
module alu_cmd_issue
  import alu_pkg::*;
#(
  parameter int DEPTH = ALU_DEPTH,
  parameter int OPW   = ALU_OPW,
  parameter int SW    = ALU_SW,
  parameter int RW    = ALU_RW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPW-1:0]         in_a,
  input  logic [OPW-1:0]         in_b,
  input  logic [SW-1:0]          in_op,
  output logic [OPW-1:0]         alu_a,
  output logic [OPW-1:0]         alu_b,
  output logic [SW-1:0]          alu_s,
  input  logic [RW-1:0]          alu_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [RW-1:0]          res_data,
  output logic [SW-1:0]          res_op,
  output logic                   res_err,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CMDW = 2*OPW + SW;

  state_t          state;
  state_t          state_nxt;
  logic [CMDW-1:0] head;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  // No bypass: a full queue refuses input even if a pop happens this cycle.
  assign in_ready  = !full;
  assign push      = in_valid && in_ready;
  assign res_valid = (state == RESULT);

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMDW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .push      (push),
    .push_data ({in_a, in_b, in_op}),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A pop loads the ALU registers; consuming a result with more work queued
  // goes straight back to SETTLE, giving one result every two cycles.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = SETTLE;
          end
        end
        SETTLE: begin
          state_nxt = RESULT;
        end
        RESULT: begin
          if (res_ready) begin
            if (!empty) begin
              pop       = 1'b1;
              state_nxt = SETTLE;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ALU operands persist after the result is consumed; only the next pop changes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a <= '0;
      alu_b <= '0;
      alu_s <= '0;
    end else if (pop) begin
      {alu_a, alu_b, alu_s} <= head;
    end
  end

  // The ALU has had a full cycle to settle on the registered operands by SETTLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data <= '0;
      res_op   <= '0;
      res_err  <= 1'b0;
    end else if (!clr && state == SETTLE) begin
      res_data <= alu_out;
      res_op   <= alu_s;
      res_err  <= alu_s[2] & alu_s[1];
    end
  end

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Self-checking bench for alu_cmd_issue with a behavioural stand-in for the combinational ALU.
// Ports: all DUT ports driven/observed; alu_out computed from alu_a/b/s in the bench.
// Directed scenarios plus a randomized run scored against a queue of accepted commands.
module tb_alu_cmd_issue;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [2:0] in_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_s;
  logic [7:0] alu_out;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [2:0] res_op;
  logic       res_err;
  logic [2:0] count;

  int vectors     = 0;
  int miscompares = 0;

  cmd_t       q[$];
  logic       held = 1'b0;
  logic [7:0] held_data;
  logic [2:0] held_op;
  logic       held_err;

  always #5 clk = ~clk;

  alu_cmd_issue #(.DEPTH(DEPTH), .OPW(4), .SW(3), .RW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_s     (alu_s),
    .alu_out   (alu_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_op    (res_op),
    .res_err   (res_err),
    .count     (count)
  );

  function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
    int r;
    case (s)
      3'd0:    r = int'(a) + int'(b);
      3'd1:    r = int'(a) - int'(b);
      3'd2:    r = int'(a) * int'(b);
      3'd3:    r = int'(a & b);
      3'd4:    r = int'(a | b);
      3'd5:    r = int'(a ^ b);
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  always_comb alu_out = alu_fn(alu_a, alu_b, alu_s);

  // One clock cycle, entered and left at a falling edge. Checks the scoreboard
  // against the visible outputs, then applies the handshake outcome to the model.
  task automatic cycle(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                       input logic rr, input logic c,
                       output logic acc, output logic rfire, output logic [7:0] rdat);
    cmd_t e;
    logic fire_in;
    logic fire_res;
    in_valid = v; in_a = a; in_b = b; in_op = op; res_ready = rr; clr = c;
    #1;
    if (q.size() == DEPTH + 1) begin
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL ready_full: in_ready=%0b with %0d outstanding, expected 0", in_ready, q.size());
      end
    end else if (q.size() < DEPTH) begin
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL ready_space: in_ready=%0b with %0d outstanding, expected 1", in_ready, q.size());
      end
    end
    vectors++;
    if (!(count <= 3'(DEPTH))) begin
      miscompares++;
      $display("FAIL count_bound: count=%0d exceeds %0d", count, DEPTH);
    end
    if (held) begin
      vectors++;
      if ({res_valid, res_data, res_op, res_err} !== {1'b1, held_data, held_op, held_err}) begin
        miscompares++;
        $display("FAIL hold: valid=%0b data=%h op=%0d err=%0b, expected 1 %h %0d %0b",
                 res_valid, res_data, res_op, res_err, held_data, held_op, held_err);
      end
    end
    if (res_valid === 1'b1) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL spurious_result: data=%h op=%0d with no command outstanding, expected res_valid=0", res_data, res_op);
      end else begin
        e = q[0];
        if ({res_data, res_op, res_err} !== {alu_fn(e.a, e.b, e.op), e.op, (e.op >= 3'd6)}) begin
          miscompares++;
          $display("FAIL result: data=%h op=%0d err=%0b, expected data=%h op=%0d err=%0b",
                   res_data, res_op, res_err, alu_fn(e.a, e.b, e.op), e.op, (e.op >= 3'd6));
        end
      end
    end
    fire_in  = v && in_ready && !c;
    fire_res = res_valid && rr && !c;
    acc   = fire_in;
    rfire = fire_res;
    rdat  = res_data;
    held_data = res_data; held_op = res_op; held_err = res_err;
    @(posedge clk);
    held = res_valid && !rr && !c;
    if (c) begin
      q.delete();
      held = 1'b0;
    end else begin
      if (fire_res && q.size() > 0) void'(q.pop_front());
      if (fire_in) q.push_back('{a: a, b: b, op: op});
    end
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n, input logic rr);
    logic acc, rf;
    logic [7:0] rd;
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 4'd0, 3'd0, rr, 1'b0, acc, rf, rd);
  endtask

  // Offer one command until it is accepted or the budget runs out.
  task automatic push_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op, input logic rr, input string name);
    logic acc, rf;
    logic [7:0] rd;
    int n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      cycle(1'b1, a, b, op, rr, 1'b0, acc, rf, rd);
      n++;
    end
    vectors++;
    if (!acc) begin
      miscompares++;
      $display("FAIL %s_accept: command not accepted in 20 cycles, expected acceptance", name);
    end
  endtask

  // Consume results until one is seen; returns its data.
  task automatic wait_result(input string name, output logic [7:0] data);
    logic acc, rf;
    logic [7:0] rd;
    int n = 0;
    rf = 1'b0; data = 8'h00;
    while (!rf && n < 20) begin
      cycle(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 1'b0, acc, rf, rd);
      n++;
    end
    data = rd;
    vectors++;
    if (!rf) begin
      miscompares++;
      $display("FAIL %s_timeout: no result within 20 cycles, expected one", name);
    end
  endtask

  task automatic test_reset;
    vectors++;
    if ({res_valid, res_data, res_op, res_err} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_res: valid=%0b data=%h op=%0d err=%0b, expected all 0", res_valid, res_data, res_op, res_err);
    end
    vectors++;
    if ({alu_a, alu_b, alu_s, count} !== 14'h0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_regs: a=%0d b=%0d s=%0d count=%0d ready=%0b, expected 0 0 0 0 1",
               alu_a, alu_b, alu_s, count, in_ready);
    end
  endtask

  task automatic test_single_add;
    logic acc, rf;
    logic [7:0] rd;
    cycle(1'b1, 4'd4, 4'd2, OP_ADD, 1'b1, 1'b0, acc, rf, rd);
    vectors++;
    if (acc !== 1'b1 || res_valid !== 1'b0 || count !== 3'd1) begin
      miscompares++;
      $display("FAIL add_e0: acc=%0b valid=%0b count=%0d, expected 1 0 1", acc, res_valid, count);
    end
    cycle(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 1'b0, acc, rf, rd);
    vectors++;
    if (res_valid !== 1'b0 || {alu_a, alu_b, alu_s} !== {4'd4, 4'd2, 3'd0}) begin
      miscompares++;
      $display("FAIL add_e1: valid=%0b a=%0d b=%0d s=%0d, expected 0 4 2 0", res_valid, alu_a, alu_b, alu_s);
    end
    cycle(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 1'b0, acc, rf, rd);
    vectors++;
    if ({res_valid, res_data, res_op, res_err} !== {1'b1, 8'd6, 3'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL add_e2: valid=%0b data=%0d op=%0d err=%0b, expected 1 6 0 0", res_valid, res_data, res_op, res_err);
    end
    cycle(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 1'b0, acc, rf, rd);
    vectors++;
    if (rf !== 1'b1 || res_valid !== 1'b0 || alu_a !== 4'd4) begin
      miscompares++;
      $display("FAIL add_done: fired=%0b valid=%0b alu_a=%0d, expected 1 0 4", rf, res_valid, alu_a);
    end
  endtask

  task automatic test_backpressure;
    logic [3:0] ca [6] = '{4'd2, 4'd15, 4'd6, 4'd3, 4'd2, 4'd1};
    logic [3:0] cb [6] = '{4'd3, 4'd15, 4'd3, 4'd9, 4'd4, 4'd1};
    logic [2:0] co [6] = '{OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_ADD};
    logic [7:0] exp_r [5] = '{8'hFF, 8'd225, 8'd2, 8'd11, 8'd6};
    logic [7:0] got [$];
    logic acc, rf;
    logic [7:0] rd;
    int idx = 0;
    for (int c = 0; c < 12; c++) begin
      cycle(1'b1, ca[idx], cb[idx], co[idx], 1'b0, 1'b0, acc, rf, rd);
      if (acc && idx < 5) idx++;
      else if (acc) idx = 6;
    end
    vectors++;
    if (idx != 5 || in_ready !== 1'b0 || count !== 3'(DEPTH) || res_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_full: accepted=%0d ready=%0b count=%0d valid=%0b, expected 5 0 %0d 1",
               idx, in_ready, count, res_valid, DEPTH);
    end
    for (int c = 0; c < 30 && got.size() < 5; c++) begin
      cycle(1'b0, 4'd0, 4'd0, 3'd0, 1'($urandom_range(0, 1)), 1'b0, acc, rf, rd);
      if (rf) got.push_back(rd);
    end
    vectors++;
    if (got.size() != 5) begin
      miscompares++;
      $display("FAIL bp_count: %0d results drained, expected 5", got.size());
    end
    for (int i = 0; i < got.size() && i < 5; i++) begin
      vectors++;
      if (got[i] !== exp_r[i]) begin
        miscompares++;
        $display("FAIL bp_result%0d: got %h, expected %h", i, got[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_reserved;
    logic [7:0] rd;
    push_cmd(4'd3, 4'd2, 3'd7, 1'b0, "rsv");
    idle_cycles(2, 1'b0);
    vectors++;
    if ({res_valid, res_data, res_op, res_err} !== {1'b1, 8'd0, 3'd7, 1'b1}) begin
      miscompares++;
      $display("FAIL reserved: valid=%0b data=%h op=%0d err=%0b, expected 1 00 7 1", res_valid, res_data, res_op, res_err);
    end
    wait_result("rsv", rd);
  endtask

  task automatic test_wrap;
    logic [7:0] got [$];
    logic acc, rf;
    logic [7:0] rd;
    int i = 0;
    for (int c = 0; c < 100 && got.size() < 12; c++) begin
      cycle(i < 12, 4'(i + 1), 4'd0, OP_ADD, 1'b1, 1'b0, acc, rf, rd);
      if (acc) i++;
      if (rf) got.push_back(rd);
    end
    vectors++;
    if (got.size() != 12) begin
      miscompares++;
      $display("FAIL wrap_count: %0d results, expected 12", got.size());
    end
    for (int k = 0; k < got.size(); k++) begin
      vectors++;
      if (got[k] !== 8'(k + 1)) begin
        miscompares++;
        $display("FAIL wrap_result%0d: got %0d, expected %0d", k, got[k], k + 1);
      end
    end
  endtask

  task automatic test_clr;
    logic acc, rf;
    logic [7:0] rd;
    logic [7:0] keep_data;
    for (int k = 0; k < 4; k++) push_cmd(4'(k + 5), 4'd1, OP_ADD, 1'b0, "clr_fill");
    vectors++;
    if (count !== 3'd3 || res_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_setup: count=%0d valid=%0b, expected 3 1", count, res_valid);
    end
    keep_data = res_data;
    cycle(1'b1, 4'd9, 4'd9, OP_ADD, 1'b1, 1'b1, acc, rf, rd);
    vectors++;
    if (count !== 3'd0 || res_valid !== 1'b0 || in_ready !== 1'b1 || res_data !== keep_data) begin
      miscompares++;
      $display("FAIL clr_flush: count=%0d valid=%0b ready=%0b data=%h, expected 0 0 1 %h",
               count, res_valid, in_ready, res_data, keep_data);
    end
    push_cmd(4'd1, 4'd1, OP_ADD, 1'b1, "clr_add");
    wait_result("clr_add", rd);
    vectors++;
    if (rd !== 8'd2) begin
      miscompares++;
      $display("FAIL clr_add: got %0d, expected 2", rd);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] rd;
    for (int k = 0; k < 3; k++) push_cmd(4'(k + 2), 4'(k), OP_MUL, 1'b0, "rst_fill");
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({res_valid, res_data, res_op, res_err, alu_a, alu_b, alu_s, count} !== 26'h0) begin
      miscompares++;
      $display("FAIL reset_mid: valid=%0b data=%h op=%0d err=%0b a=%0d b=%0d s=%0d count=%0d, expected all 0",
               res_valid, res_data, res_op, res_err, alu_a, alu_b, alu_s, count);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    held = 1'b0;
    idle_cycles(2, 1'b1);
    push_cmd(4'd4, 4'd2, OP_ADD, 1'b1, "rst_add");
    wait_result("rst_add", rd);
    vectors++;
    if (rd !== 8'd6) begin
      miscompares++;
      $display("FAIL rst_add: got %0d, expected 6", rd);
    end
  endtask

  task automatic test_random;
    logic acc, rf;
    logic [7:0] rd;
    for (int c = 0; c < 400; c++)
      cycle(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 2) != 0), 1'b0, acc, rf, rd);
    for (int c = 0; c < 60 && q.size() > 0; c++) idle_cycles(1, 1'b1);
    vectors++;
    if (q.size() != 0 || res_valid !== 1'b0 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL random_drain: %0d outstanding valid=%0b count=%0d, expected 0 0 0", q.size(), res_valid, count);
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; res_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    test_reset;
    @(negedge clk);
    test_single_add;
    test_backpressure;
    test_reserved;
    test_wrap;
    test_clr;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
